mem_line_ctrl: RTL and testbench

//  Parametrised bus2-side main-memory controller: next generation of the line memory controller.

---
 rtl/mem_line_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_line_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_line_ctrl.sv
// Bus2-side main-memory line controller: serves whole cache lines to the L1
// over split A2/D2/C2 signals with a fixed access latency for reads and writes.
module mem_line_ctrl #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned MEM_LINES  = 2**ADDR_W,
  parameter int unsigned DELAY      = 100
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] a2_in,
  input  logic [DATA_W-1:0] d2_in,
  input  logic [1:0]        c2_in,
  output logic [DATA_W-1:0] d2_out,
  output logic              d2_oe,
  output logic [1:0]        c2_out,
  output logic              c2_oe,
  output logic              busy
);

  localparam int unsigned BB     = DATA_W / 8;
  localparam int unsigned BEATS  = LINE_BYTES / BB;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IDX_W  = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int unsigned CNT_W  = $clog2(DELAY + BEATS + 1);

  localparam logic [1:0] C2_NOP = 2'd0;
  localparam logic [1:0] C2_RSP = 2'd1;
  localparam logic [1:0] C2_RD  = 2'd2;
  localparam logic [1:0] C2_WR  = 2'd3;

  if (DATA_W % 8 != 0 || DATA_W == 0) begin : g_chk_data
    $error("DATA_W must be a non-zero multiple of 8");
  end
  if (LINE_BYTES % BB != 0 || LINE_BYTES < BB) begin : g_chk_line
    $error("LINE_BYTES must be a multiple of DATA_W/8");
  end
  if (DELAY < BEATS + 1) begin : g_chk_delay
    $error("DELAY must be at least BEATS+1");
  end
  if ((1 << IDX_W) != MEM_LINES || IDX_W > ADDR_W) begin : g_chk_lines
    $error("MEM_LINES must be a power of two not exceeding 2**ADDR_W");
  end

  typedef enum logic [1:0] {IDLE, WR_RECV, WAIT, RD_SEND} state_e;

  // Beat i of a line sits in packed slot i, so byte b of beat i is line byte i*BB+b.
  logic [BEATS-1:0][DATA_W-1:0] mem_q [MEM_LINES];

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [IDX_W-1:0]   idx_q;
  logic               is_rd_q;
  logic [DATA_W-1:0]  d2_out_q;
  logic               d2_oe_q;
  logic [1:0]         c2_out_q;
  logic               c2_oe_q;
  logic               busy_q;

  logic               mem_we_c;
  logic [IDX_W-1:0]   mem_idx_c;
  logic [BEAT_W-1:0]  mem_beat_c;
  logic               unused_addr_c;

  assign unused_addr_c = ^a2_in;

  // Beat 0 is captured on the command edge itself, before the index is latched.
  always_comb begin
    mem_we_c   = 1'b0;
    mem_idx_c  = idx_q;
    mem_beat_c = beat_q;
    if (RESET) begin
      if (state_q == IDLE && c2_in == C2_WR) begin
        mem_we_c   = 1'b1;
        mem_idx_c  = a2_in[IDX_W-1:0];
        mem_beat_c = '0;
      end else if (state_q == WR_RECV) begin
        mem_we_c = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we_c) mem_q[mem_idx_c][mem_beat_c] <= d2_in;
  end

  // cnt_q holds the number of the upcoming edge, counted from the command edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      idx_q    <= '0;
      is_rd_q  <= 1'b0;
      d2_out_q <= '0;
      d2_oe_q  <= 1'b0;
      c2_out_q <= C2_NOP;
      c2_oe_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= CNT_W'(1);
          if (c2_in == C2_RD || c2_in == C2_WR) begin
            idx_q    <= a2_in[IDX_W-1:0];
            is_rd_q  <= (c2_in == C2_RD);
            busy_q   <= 1'b1;
            c2_oe_q  <= 1'b1;
            c2_out_q <= C2_NOP;
            beat_q   <= BEAT_W'(1);
            if (c2_in == C2_WR && BEATS > 1) state_q <= WR_RECV;
            else                             state_q <= WAIT;
          end
        end
        WR_RECV: begin
          beat_q <= beat_q + 1'b1;
          if (beat_q == BEAT_W'(BEATS - 1)) state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == CNT_W'(DELAY)) begin
            c2_out_q <= C2_RSP;
            if (is_rd_q) begin
              state_q  <= RD_SEND;
              d2_oe_q  <= 1'b1;
              d2_out_q <= mem_q[idx_q][0];
              beat_q   <= BEAT_W'(1);
            end
          end else if (cnt_q == CNT_W'(DELAY + 1)) begin
            state_q  <= IDLE;
            c2_out_q <= C2_NOP;
            c2_oe_q  <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        RD_SEND: begin
          if (cnt_q == CNT_W'(DELAY + BEATS)) begin
            state_q  <= IDLE;
            d2_oe_q  <= 1'b0;
            d2_out_q <= '0;
            c2_out_q <= C2_NOP;
            c2_oe_q  <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            d2_out_q <= mem_q[idx_q][beat_q];
            beat_q   <= beat_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d2_out = d2_out_q;
  assign d2_oe  = d2_oe_q;
  assign c2_out = c2_out_q;
  assign c2_oe  = c2_oe_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed bench for mem_line_ctrl: write/read latency, collision, address wrap
// and asynchronous reset in the middle of a read burst.
module tb_mem_line_ctrl;

  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] RSP = 2'd1;
  localparam logic [1:0] RD  = 2'd2;
  localparam logic [1:0] WR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  a2_in;
  logic [15:0] d2_in;
  logic [1:0]  c2_in;
  logic [15:0] d2_out;
  logic        d2_oe;
  logic [1:0]  c2_out;
  logic        c2_oe;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] pat_a [8] = '{16'h0100, 16'h0302, 16'h0504, 16'h0706,
                             16'h0908, 16'h0B0A, 16'h0D0C, 16'h0F0E};
  logic [15:0] pat_b [8] = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D,
                             16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  logic [15:0] pat_c [8] = '{16'hA0A1, 16'hB2B3, 16'hC4C5, 16'hD6D7,
                             16'hE8E9, 16'hFAFB, 16'h0C0D, 16'h1E1F};

  mem_line_ctrl #(
    .ADDR_W(5), .DATA_W(16), .LINE_BYTES(16), .MEM_LINES(16), .DELAY(12)
  ) dut (
    .CLK(CLK), .RESET(RESET), .a2_in(a2_in), .d2_in(d2_in), .c2_in(c2_in),
    .d2_out(d2_out), .d2_oe(d2_oe), .c2_out(c2_out), .c2_oe(c2_oe), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] pat(input int which, input int i);
    case (which)
      0:       return pat_a[i];
      1:       return pat_b[i];
      default: return pat_c[i];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"},   32'(busy),   32'd0);
    chk({tag, " c2_oe"},  32'(c2_oe),  32'd0);
    chk({tag, " d2_oe"},  32'(d2_oe),  32'd0);
    chk({tag, " c2_out"}, 32'(c2_out), 32'(NOP));
  endtask

  // Write a line; optionally fire a colliding READ_LINE a2=5 in cycles 4..5.
  task automatic do_write(input logic [4:0] a, input int which, input bit collide);
    c2_in = WR; a2_in = a; d2_in = pat(which, 0);
    for (int n = 0; n <= 13; n++) begin
      tick;
      c2_in = NOP;
      d2_in = (n + 1 < 8) ? pat(which, n + 1) : 16'h0000;
      if (collide && (n == 4 || n == 5)) begin
        c2_in = RD; a2_in = 5'd5;
      end
      if (n <= 12) begin
        chk($sformatf("wr c%0d busy", n),   32'(busy),   32'd1);
        chk($sformatf("wr c%0d c2_oe", n),  32'(c2_oe),  32'd1);
        chk($sformatf("wr c%0d d2_oe", n),  32'(d2_oe),  32'd0);
        chk($sformatf("wr c%0d c2_out", n), 32'(c2_out), (n == 12) ? 32'(RSP) : 32'(NOP));
      end else begin
        chk_idle($sformatf("wr c%0d", n));
      end
    end
    c2_in = NOP;
  endtask

  task automatic do_read(input logic [4:0] a, input int which, input int stop);
    c2_in = RD; a2_in = a;
    for (int n = 0; n <= stop; n++) begin
      tick;
      c2_in = NOP;
      if (n < 12) begin
        chk($sformatf("rd c%0d busy", n),   32'(busy),   32'd1);
        chk($sformatf("rd c%0d c2_oe", n),  32'(c2_oe),  32'd1);
        chk($sformatf("rd c%0d d2_oe", n),  32'(d2_oe),  32'd0);
        chk($sformatf("rd c%0d c2_out", n), 32'(c2_out), 32'(NOP));
      end else if (n <= 19) begin
        chk($sformatf("rd c%0d busy", n),   32'(busy),   32'd1);
        chk($sformatf("rd c%0d c2_oe", n),  32'(c2_oe),  32'd1);
        chk($sformatf("rd c%0d d2_oe", n),  32'(d2_oe),  32'd1);
        chk($sformatf("rd c%0d c2_out", n), 32'(c2_out), 32'(RSP));
        chk($sformatf("rd c%0d d2_out", n), 32'(d2_out), 32'(pat(which, n - 12)));
      end else begin
        chk_idle($sformatf("rd c%0d", n));
      end
    end
  endtask

  initial begin
    RESET = 1'b1; c2_in = NOP; a2_in = '0; d2_in = '0;

    // Reset asserted mid-cycle, before any clock edge
    #2 RESET = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset d2_out", 32'(d2_out), 32'd0);
    tick; tick;
    @(negedge CLK) RESET = 1'b1;
    tick;
    chk_idle("post-reset");

    // Write then read line 3
    do_write(5'd3, 0, 1'b0);
    do_read(5'd3, 0, 20);

    // Colliding READ_LINE during a write is ignored
    do_write(5'd7, 1, 1'b1);
    tick;
    chk_idle("collide after");
    do_read(5'd7, 1, 20);

    // a2=19 aliases line 3 with 16 lines
    do_write(5'd19, 2, 1'b0);
    do_read(5'd3, 2, 20);

    // Reset in cycle 14 of a read releases the bus at once
    do_read(5'd3, 2, 14);
    #2 RESET = 1'b0;
    #1;
    chk_idle("midread reset");
    chk("midread reset d2_out", 32'(d2_out), 32'd0);
    #2 RESET = 1'b1;
    do_write(5'd3, 1, 1'b0);
    do_read(5'd3, 1, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
